// File: rtl/id_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : id_hazard_ctrl_if
// Brief    : Decode-stage hazard bus: read ports, EX/MEM/WB write-back taps,
//            long-latency issue/complete and resolved operands / stall.
// Revision : 1.0 - initial release
// ============================================================================
interface id_hazard_ctrl_if #(
    parameter int NUM_RD = 2,
    parameter int DW     = 32,
    parameter int AW     = 5
);
    logic [NUM_RD-1:0]    rd_en_i;
    logic [NUM_RD*AW-1:0] rd_addr_i;
    logic [NUM_RD*DW-1:0] rf_data_i;
    logic                 ex_we_i;
    logic [AW-1:0]        ex_waddr_i;
    logic [DW-1:0]        ex_wdata_i;
    logic                 ex_is_load_i;
    logic                 mem_we_i;
    logic [AW-1:0]        mem_waddr_i;
    logic [DW-1:0]        mem_wdata_i;
    logic                 wb_we_i;
    logic [AW-1:0]        wb_waddr_i;
    logic [DW-1:0]        wb_wdata_i;
    logic                 lng_issue_i;
    logic [AW-1:0]        lng_waddr_i;
    logic                 lng_done_i;
    logic [AW-1:0]        lng_done_addr_i;
    logic [NUM_RD*DW-1:0] rdata_o;
    logic                 stall_o;
    logic                 hang_o;

    modport master (
        output rd_en_i, rd_addr_i, rf_data_i,
        output ex_we_i, ex_waddr_i, ex_wdata_i, ex_is_load_i,
        output mem_we_i, mem_waddr_i, mem_wdata_i,
        output wb_we_i, wb_waddr_i, wb_wdata_i,
        output lng_issue_i, lng_waddr_i, lng_done_i, lng_done_addr_i,
        input  rdata_o, stall_o, hang_o
    );

    modport slave (
        input  rd_en_i, rd_addr_i, rf_data_i,
        input  ex_we_i, ex_waddr_i, ex_wdata_i, ex_is_load_i,
        input  mem_we_i, mem_waddr_i, mem_wdata_i,
        input  wb_we_i, wb_waddr_i, wb_wdata_i,
        input  lng_issue_i, lng_waddr_i, lng_done_i, lng_done_addr_i,
        output rdata_o, stall_o, hang_o
    );
endinterface
`default_nettype wire

// File: rtl/id_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : id_hazard_ctrl
// Brief    : Operand forwarding, load-use / long-latency scoreboard stalls and
//            stall watchdog. Optional perf counters under HAZARD_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module id_hazard_ctrl #(
    parameter int NUM_RD    = 2,
    parameter int DW        = 32,
    parameter int AW        = 5,
    parameter int MAX_STALL = 63
) (
    input  logic                clk_i,
    input  logic                rst_i,
    id_hazard_ctrl_if.slave     bus
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]         stall_cnt_o,
    output logic [31:0]         lu_cnt_o
`endif
);

    localparam int                 c_run_w   = $clog2(MAX_STALL + 1) + 1;
    localparam int                 c_sb_n    = 2 ** AW;
    localparam logic [c_run_w-1:0] c_run_sat = '1;
    localparam logic [c_run_w-1:0] c_hang_at = c_run_w'(MAX_STALL);

    logic [c_sb_n-1:0]  r_sb;
    logic [c_run_w-1:0] r_run_cnt;
    logic               r_hang;
    logic [NUM_RD-1:0]  w_lu_hz;
    logic [NUM_RD-1:0]  w_sb_hz;
    logic               w_lu_any;
    logic               w_stall;

    generate
        for (genvar gk = 0; gk < NUM_RD; gk++) begin : g_port
            logic [AW-1:0] w_addr;
            logic          w_nz;
            logic [DW-1:0] w_data;

            assign w_addr = bus.rd_addr_i[gk*AW +: AW];
            assign w_nz   = |w_addr;

            // Youngest producer wins: EX, then MEM, then WB, then the file.
            always_comb begin
                w_data = bus.rf_data_i[gk*DW +: DW];
                if (rst_i || !w_nz)
                    w_data = '0;
                else if (bus.ex_we_i && (bus.ex_waddr_i == w_addr))
                    w_data = bus.ex_wdata_i;
                else if (bus.mem_we_i && (bus.mem_waddr_i == w_addr))
                    w_data = bus.mem_wdata_i;
                else if (bus.wb_we_i && (bus.wb_waddr_i == w_addr))
                    w_data = bus.wb_wdata_i;
            end

            assign bus.rdata_o[gk*DW +: DW] = w_data;

            assign w_lu_hz[gk] = bus.rd_en_i[gk] && w_nz && bus.ex_we_i &&
                                 bus.ex_is_load_i && (bus.ex_waddr_i == w_addr);

            // A completing result arrives on WB this cycle, so no stall is needed.
            assign w_sb_hz[gk] = bus.rd_en_i[gk] && w_nz && r_sb[w_addr] &&
                                 !(bus.lng_done_i && (bus.lng_done_addr_i == w_addr));
        end
    endgenerate

    assign w_lu_any    = !rst_i && (|w_lu_hz);
    assign w_stall     = !rst_i && ((|w_lu_hz) || (|w_sb_hz));
    assign bus.stall_o = w_stall;
    assign bus.hang_o  = r_hang;

    // Later assignment wins, so an issue overrides a completion on the same register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sb <= '0;
        end else begin
            if (bus.lng_done_i)
                r_sb[bus.lng_done_addr_i] <= 1'b0;
            if (bus.lng_issue_i && (|bus.lng_waddr_i))
                r_sb[bus.lng_waddr_i] <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_run_cnt <= '0;
            r_hang    <= 1'b0;
        end else begin
            if (!w_stall)
                r_run_cnt <= '0;
            else if (r_run_cnt != c_run_sat)
                r_run_cnt <= r_run_cnt + 1'b1;
            if (w_stall && (r_run_cnt == c_hang_at))
                r_hang <= 1'b1;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_lu_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stall_cnt <= '0;
            r_lu_cnt    <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF))
                r_stall_cnt <= r_stall_cnt + 32'd1;
            if (w_lu_any && (r_lu_cnt != 32'hFFFF_FFFF))
                r_lu_cnt <= r_lu_cnt + 32'd1;
        end
    end

    assign stall_cnt_o = r_stall_cnt;
    assign lu_cnt_o    = r_lu_cnt;
`else
    logic w_unused;
    assign w_unused = w_lu_any;
`endif

endmodule
`default_nettype wire

// File: tb/tb_id_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_hazard_ctrl
// Brief    : Self-checking bench for id_hazard_ctrl (vectors, corner sequences,
//            random stimulus against a reference model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_hazard_ctrl;
    localparam int NUM_RD    = 2;
    localparam int DW        = 32;
    localparam int AW        = 5;
    localparam int MAX_STALL = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    id_hazard_ctrl_if #(.NUM_RD(NUM_RD), .DW(DW), .AW(AW)) bus ();

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] lu_cnt;
`endif

    id_hazard_ctrl #(.NUM_RD(NUM_RD), .DW(DW), .AW(AW), .MAX_STALL(MAX_STALL)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .bus         (bus)
`ifdef HAZARD_PERF_EN
        ,
        .stall_cnt_o (stall_cnt),
        .lu_cnt_o    (lu_cnt)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [1:0]  en;
        logic [4:0]  a0, a1;
        logic [31:0] rf0, rf1;
        logic        exw; logic [4:0] exa; logic [31:0] exd; logic exl;
        logic        mw;  logic [4:0] ma;  logic [31:0] md;
        logic        ww;  logic [4:0] wa;  logic [31:0] wd;
        logic [31:0] e0, e1;
        logic        es;
    } vec_t;

    vec_t vt [9];

    // Reference model state
    bit          m_sb [32];
    int          m_consec;
    bit          m_hang;
    longint      m_sc, m_lc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h required 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.rd_en_i = '0; bus.rd_addr_i = '0; bus.rf_data_i = '0;
        bus.ex_we_i = 0; bus.ex_waddr_i = '0; bus.ex_wdata_i = '0; bus.ex_is_load_i = 0;
        bus.mem_we_i = 0; bus.mem_waddr_i = '0; bus.mem_wdata_i = '0;
        bus.wb_we_i = 0; bus.wb_waddr_i = '0; bus.wb_wdata_i = '0;
        bus.lng_issue_i = 0; bus.lng_waddr_i = '0; bus.lng_done_i = 0; bus.lng_done_addr_i = '0;
    endtask

    task automatic rd(input int k, input logic [4:0] a, input logic [31:0] rf);
        bus.rd_en_i[k] = 1'b1;
        bus.rd_addr_i[k*AW +: AW] = a;
        bus.rf_data_i[k*DW +: DW] = rf;
    endtask

    task automatic apply_vec(input vec_t v);
        idle();
        bus.rd_en_i = v.en;
        bus.rd_addr_i = {v.a1, v.a0};
        bus.rf_data_i = {v.rf1, v.rf0};
        bus.ex_we_i = v.exw; bus.ex_waddr_i = v.exa; bus.ex_wdata_i = v.exd; bus.ex_is_load_i = v.exl;
        bus.mem_we_i = v.mw; bus.mem_waddr_i = v.ma; bus.mem_wdata_i = v.md;
        bus.wb_we_i = v.ww; bus.wb_waddr_i = v.wa; bus.wb_wdata_i = v.wd;
    endtask

    // Expected outputs come from the rules directly; the model then advances its state.
    task automatic model_cycle();
        logic        we [3];
        logic [4:0]  wa [3];
        logic [31:0] wd [3];
        logic [4:0]  a;
        logic [31:0] e;
        logic        es, lu_any;
        we = '{bus.ex_we_i, bus.mem_we_i, bus.wb_we_i};
        wa = '{bus.ex_waddr_i, bus.mem_waddr_i, bus.wb_waddr_i};
        wd = '{bus.ex_wdata_i, bus.mem_wdata_i, bus.wb_wdata_i};
        es = 0; lu_any = 0;
        for (int k = 0; k < NUM_RD; k++) begin
            a = bus.rd_addr_i[k*AW +: AW];
            e = bus.rf_data_i[k*DW +: DW];
            for (int s = 2; s >= 0; s--)
                if (we[s] && wa[s] == a) e = wd[s];
            if (rst || a == 0) e = 0;
            check($sformatf("rnd_rdata%0d", k), bus.rdata_o[k*DW +: DW], e);
            if (bus.rd_en_i[k] && a != 0) begin
                if (bus.ex_we_i && bus.ex_is_load_i && bus.ex_waddr_i == a) lu_any = 1;
                if (m_sb[a] && !(bus.lng_done_i && bus.lng_done_addr_i == a)) es = 1;
            end
        end
        if (rst) begin es = 0; lu_any = 0; end
        es = es | lu_any;
        check("rnd_stall", {31'd0, bus.stall_o}, {31'd0, es});
        check("rnd_hang", {31'd0, bus.hang_o}, {31'd0, m_hang});
`ifdef HAZARD_PERF_EN
        check("rnd_stall_cnt", stall_cnt, m_sc[31:0]);
        check("rnd_lu_cnt", lu_cnt, m_lc[31:0]);
`endif
        if (rst) begin
            foreach (m_sb[i]) m_sb[i] = 0;
            m_consec = 0; m_hang = 0; m_sc = 0; m_lc = 0;
        end else begin
            if (bus.lng_done_i) m_sb[bus.lng_done_addr_i] = 0;
            if (bus.lng_issue_i && bus.lng_waddr_i != 0) m_sb[bus.lng_waddr_i] = 1;
            m_consec = es ? m_consec + 1 : 0;
            if (m_consec > MAX_STALL) m_hang = 1;
            if (es && m_sc < 64'hFFFF_FFFF) m_sc++;
            if (lu_any && m_lc < 64'hFFFF_FFFF) m_lc++;
        end
    endtask

    initial begin
        // en a0 a1 rf0 rf1 | ex we/addr/data/load | mem | wb | exp0 exp1 stall
        vt[0] = '{2'b11, 5'd3, 5'd4, 32'hAAAA, 32'hBBBB, 1, 5'd3, 32'h11, 0, 1, 5'd3, 32'h22, 1, 5'd3, 32'h33, 32'h11, 32'hBBBB, 0};
        vt[1] = '{2'b11, 5'd3, 5'd4, 32'hAAAA, 32'hBBBB, 0, 5'd3, 32'h11, 0, 1, 5'd3, 32'h22, 1, 5'd3, 32'h33, 32'h22, 32'hBBBB, 0};
        vt[2] = '{2'b11, 5'd3, 5'd4, 32'hAAAA, 32'hBBBB, 0, 5'd3, 32'h11, 0, 0, 5'd3, 32'h22, 1, 5'd3, 32'h33, 32'h33, 32'hBBBB, 0};
        vt[3] = '{2'b11, 5'd3, 5'd4, 32'hAAAA, 32'hBBBB, 0, 5'd3, 32'h11, 0, 0, 5'd3, 32'h22, 0, 5'd3, 32'h33, 32'hAAAA, 32'hBBBB, 0};
        vt[4] = '{2'b11, 5'd0, 5'd0, 32'h1234, 32'h5678, 1, 5'd0, 32'hFFFF, 1, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 32'h0, 32'h0, 0};
        vt[5] = '{2'b10, 5'd1, 5'd7, 32'h5, 32'h99, 1, 5'd7, 32'hDEAD, 1, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 32'h5, 32'hDEAD, 1};
        vt[6] = '{2'b00, 5'd1, 5'd7, 32'h5, 32'h99, 1, 5'd7, 32'hDEAD, 1, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 32'h5, 32'hDEAD, 0};
        vt[7] = '{2'b11, 5'd9, 5'd2, 32'h1, 32'h2, 1, 5'd9, 32'hBEEF, 1, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 32'hBEEF, 32'h2, 1};
        vt[8] = '{2'b11, 5'd8, 5'd6, 32'h1, 32'h2, 1, 5'd7, 32'hDEAD, 1, 1, 5'd8, 32'h77, 1, 5'd6, 32'h66, 32'h77, 32'h66, 0};

        // Reset: outputs forced low even with a live load-use pattern
        rst = 1'b1;
        idle();
        rd(0, 5'd7, 32'h1111); rd(1, 5'd2, 32'h2222);
        bus.ex_we_i = 1; bus.ex_waddr_i = 5'd7; bus.ex_is_load_i = 1; bus.ex_wdata_i = 32'h3333;
        @(negedge clk);
        check("reset_rdata0", bus.rdata_o[31:0], 32'h0);
        check("reset_rdata1", bus.rdata_o[63:32], 32'h0);
        check("reset_stall", {31'd0, bus.stall_o}, 32'h0);
        cyc();
        @(negedge clk);
        check("reset_hang", {31'd0, bus.hang_o}, 32'h0);
        cyc();
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            apply_vec(vt[i]);
            @(negedge clk);
            check($sformatf("vec%0d_rdata0", i), bus.rdata_o[31:0], vt[i].e0);
            check($sformatf("vec%0d_rdata1", i), bus.rdata_o[63:32], vt[i].e1);
            check($sformatf("vec%0d_stall", i), {31'd0, bus.stall_o}, {31'd0, vt[i].es});
            check($sformatf("vec%0d_hang", i), {31'd0, bus.hang_o}, 32'h0);
            cyc();
        end

        idle(); rst = 1'b1; cyc(); rst = 1'b0;

        // Load-use: one bubble, then the load data comes from MEM
        idle(); rd(1, 5'd7, 32'h1);
        bus.ex_we_i = 1; bus.ex_waddr_i = 5'd7; bus.ex_is_load_i = 1; bus.ex_wdata_i = 32'hDEAD;
        @(negedge clk);
        check("lu_stall", {31'd0, bus.stall_o}, 32'h1);
        cyc();
        idle(); rd(1, 5'd7, 32'h1);
        bus.mem_we_i = 1; bus.mem_waddr_i = 5'd7; bus.mem_wdata_i = 32'hABCD;
        @(negedge clk);
        check("lu_mem_fwd", bus.rdata_o[63:32], 32'hABCD);
        check("lu_release", {31'd0, bus.stall_o}, 32'h0);
        cyc();

        // Scoreboard stall held 5 cycles; watchdog trips after the 4th
        idle(); bus.lng_issue_i = 1; bus.lng_waddr_i = 5'd9;
        @(negedge clk);
        check("sb_issue_nostall", {31'd0, bus.stall_o}, 32'h0);
        cyc();
        for (int i = 0; i < 5; i++) begin
            idle(); rd(0, 5'd9, 32'h1);
            @(negedge clk);
            check($sformatf("sb_stall%0d", i), {31'd0, bus.stall_o}, 32'h1);
            check($sformatf("sb_hang%0d", i), {31'd0, bus.hang_o}, (i == 4) ? 32'h1 : 32'h0);
            cyc();
        end
        idle(); rd(0, 5'd9, 32'h1);
        bus.lng_done_i = 1; bus.lng_done_addr_i = 5'd9;
        bus.wb_we_i = 1; bus.wb_waddr_i = 5'd9; bus.wb_wdata_i = 32'h55;
        @(negedge clk);
        check("sb_done_stall", {31'd0, bus.stall_o}, 32'h0);
        check("sb_done_rdata", bus.rdata_o[31:0], 32'h55);
        cyc();
        idle(); rd(0, 5'd9, 32'h3);
        @(negedge clk);
        check("sb_cleared_stall", {31'd0, bus.stall_o}, 32'h0);
        check("sb_cleared_rdata", bus.rdata_o[31:0], 32'h3);
        check("hang_sticky", {31'd0, bus.hang_o}, 32'h1);
`ifdef HAZARD_PERF_EN
        check("perf_stall_cnt", stall_cnt, 32'd6);
        check("perf_lu_cnt", lu_cnt, 32'd1);
`endif
        cyc();
        idle(); rst = 1'b1; cyc(); rst = 1'b0;
        @(negedge clk);
        check("hang_reset", {31'd0, bus.hang_o}, 32'h0);
        cyc();

        // Same-edge issue and done on r9: set wins
        idle(); bus.lng_issue_i = 1; bus.lng_waddr_i = 5'd9; cyc();
        idle(); rd(0, 5'd9, 32'h1);
        bus.lng_issue_i = 1; bus.lng_waddr_i = 5'd9;
        bus.lng_done_i = 1; bus.lng_done_addr_i = 5'd9;
        bus.wb_we_i = 1; bus.wb_waddr_i = 5'd9; bus.wb_wdata_i = 32'h42;
        @(negedge clk);
        check("sb_same_stall", {31'd0, bus.stall_o}, 32'h0);
        check("sb_same_rdata", bus.rdata_o[31:0], 32'h42);
        cyc();
        idle(); rd(0, 5'd9, 32'h1);
        @(negedge clk);
        check("sb_same_still_set", {31'd0, bus.stall_o}, 32'h1);
        cyc();
        idle(); bus.lng_done_i = 1; bus.lng_done_addr_i = 5'd9; cyc();
        idle(); rd(0, 5'd9, 32'h1);
        @(negedge clk);
        check("sb_same_cleared", {31'd0, bus.stall_o}, 32'h0);
        cyc();

        // Reset in the middle of a stall with pending bits
        idle(); bus.lng_issue_i = 1; bus.lng_waddr_i = 5'd9; cyc();
        idle(); bus.lng_issue_i = 1; bus.lng_waddr_i = 5'd4; cyc();
        idle(); rd(0, 5'd9, 32'h10); rd(1, 5'd4, 32'h20);
        @(negedge clk);
        check("mid_stall", {31'd0, bus.stall_o}, 32'h1);
        cyc();
        rst = 1'b1;
        bus.ex_we_i = 1; bus.ex_waddr_i = 5'd4; bus.ex_is_load_i = 1;
        @(negedge clk);
        check("mid_rst_stall", {31'd0, bus.stall_o}, 32'h0);
        check("mid_rst_rdata0", bus.rdata_o[31:0], 32'h0);
        check("mid_rst_rdata1", bus.rdata_o[63:32], 32'h0);
        cyc();
        rst = 1'b0;
        idle(); rd(0, 5'd9, 32'h10); rd(1, 5'd4, 32'h20);
        @(negedge clk);
        check("post_rst_stall", {31'd0, bus.stall_o}, 32'h0);
        check("post_rst_rdata0", bus.rdata_o[31:0], 32'h10);
        check("post_rst_rdata1", bus.rdata_o[63:32], 32'h20);
        check("post_rst_hang", {31'd0, bus.hang_o}, 32'h0);
`ifdef HAZARD_PERF_EN
        check("post_rst_stall_cnt", stall_cnt, 32'd0);
        check("post_rst_lu_cnt", lu_cnt, 32'd0);
`endif
        cyc();

        // Random traffic over a small register window to force collisions
        foreach (m_sb[i]) m_sb[i] = 0;
        m_consec = 0; m_hang = 0; m_sc = 0; m_lc = 0;
        for (int n = 0; n < 2000; n++) begin
            rst = (n == 0) || ($urandom_range(0, 63) == 0);
            bus.rd_en_i = 2'($urandom_range(0, 3));
            bus.rd_addr_i = {5'($urandom_range(0, 5)), 5'($urandom_range(0, 5))};
            bus.rf_data_i = {$urandom, $urandom};
            bus.ex_we_i = 1'($urandom_range(0, 1));
            bus.ex_waddr_i = 5'($urandom_range(0, 5));
            bus.ex_wdata_i = $urandom;
            bus.ex_is_load_i = ($urandom_range(0, 3) == 0);
            bus.mem_we_i = 1'($urandom_range(0, 1));
            bus.mem_waddr_i = 5'($urandom_range(0, 5));
            bus.mem_wdata_i = $urandom;
            bus.wb_we_i = 1'($urandom_range(0, 1));
            bus.wb_waddr_i = 5'($urandom_range(0, 5));
            bus.wb_wdata_i = $urandom;
            bus.lng_issue_i = ($urandom_range(0, 3) == 0);
            bus.lng_waddr_i = 5'($urandom_range(0, 5));
            bus.lng_done_i = ($urandom_range(0, 2) == 0);
            bus.lng_done_addr_i = 5'($urandom_range(0, 5));
            @(negedge clk);
            model_cycle();
            cyc();
        end
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
